// File: rtl/pc_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit_if
// Groups the two handshakes of the fetch unit:
//   - instruction-memory fetch port (imem_req/imem_addr -> imem_ack/imem_rdata)
//   - decode presentation port      (instr/instr_valid  -> instr_ready)
// Modports:
//   master : the fetch unit (drives request, address, instruction, valid)
//   slave  : memory + decode side (drives ack, read data, ready)
// ----------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer for the
// single-issue cpu. Fetches the word at pc over a req/ack handshake, holds it
// for decode over a valid/ready handshake, and loads npc on decode accept.
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   synchronous active-low reset
//   npc          in   32  next pc from next-pc logic
//   pc           out  32  current pc
//   fif          if       master side of pc_fetch_unit_if
//                         (imem_req/imem_addr/imem_ack/imem_rdata,
//                          instr/instr_valid/instr_ready)
//   instr_count  out  32  retired-fetch counter (modulo 2^32)
//   fetch_exc    out  1   one-cycle pulse on misaligned-npc redirect
//
// Configuration macro:
//   FETCH_ALIGN_CHECK_EN  defined   -> misaligned npc redirects to EXC_VECTOR
//                                      and pulses fetch_exc
//                         undefined -> npc low bits are cleared, fetch_exc=0
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            npc,
    output logic [31:0]            pc,
    pc_fetch_unit_if.master        fif,
    output logic [31:0]            instr_count,
    output logic                   fetch_exc
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] instr_r;
    logic [31:0] instr_nxt_s;
    logic [31:0] count_r;
    logic [31:0] count_nxt_s;
    logic        exc_r;
    logic        exc_nxt_s;
    logic        req_r;
    logic        valid_r;

    // Word-alignment test on an instruction address.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

`ifndef FETCH_ALIGN_CHECK_EN
    // Low npc bits and the exception vector have no role without the check.
    logic unused_align_s;
    assign unused_align_s = ^{EXC_VECTOR, npc[1:0]};
`endif

    // Next-state, next-pc, instruction capture and counter logic.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        count_nxt_s = count_r;
        exc_nxt_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                // ack is only meaningful while a request is outstanding
                if (fif.imem_ack) begin
                    instr_nxt_s = fif.imem_rdata;
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_HOLD: begin
                // imem_ack is ignored here: no request is outstanding
                if (fif.instr_ready) begin
                    state_nxt_s = S_FETCH;
                    count_nxt_s = count_r + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (is_misaligned(npc)) begin
                        pc_nxt_s  = EXC_VECTOR;
                        exc_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s  = npc;
                    end
`else
                    pc_nxt_s = {npc[31:2], 2'b00};
`endif
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            default: begin
                state_nxt_s = S_FETCH;
            end
        endcase
    end

    // State and datapath registers; output flags are registered from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            count_r <= 32'h0000_0000;
            exc_r   <= 1'b0;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            count_r <= count_nxt_s;
            exc_r   <= exc_nxt_s;
            req_r   <= (state_nxt_s == S_FETCH);
            valid_r <= (state_nxt_s == S_HOLD);
        end
    end

    // req_r is 1 out of reset, so the request must be masked while rst_n is low.
    assign fif.imem_req    = req_r & rst_n;
    assign fif.imem_addr   = pc_r;
    assign fif.instr       = instr_r;
    assign fif.instr_valid = valid_r;
    assign pc              = pc_r;
    assign instr_count     = count_r;
    assign fetch_exc       = exc_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Table-driven bench for pc_fetch_unit: a vector table covers reset, a
// zero-wait stream, a memory wait and a decode stall; hand-written sequences
// cover the misaligned redirect, reset while holding and counter wrap.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] instr_count;
    logic        fetch_exc;
    logic        npc_ovr_en;
    logic [31:0] npc_ovr;

    int n_checks;
    int n_fails;

    pc_fetch_unit_if fif();

    pc_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .pc          (pc),
        .fif         (fif),
        .instr_count (instr_count),
        .fetch_exc   (fetch_exc)
    );

    // Next-pc logic model: sequential pc+4 unless a test overrides it.
    assign npc = npc_ovr_en ? npc_ovr : (pc + 32'd4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] e_pc;
        logic        e_req;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                                input logic rd, input logic [31:0] p, input logic q,
                                input logic [31:0] i, input logic v, input logic [31:0] c);
        vec_t t;
        t.rst_n = r; t.ack = a; t.rdata = d; t.ready = rd;
        t.e_pc = p; t.e_req = q; t.e_instr = i; t.e_valid = v; t.e_count = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic a, input logic [31:0] d, input logic rd);
        @(negedge clk);
        rst_n           = r;
        fif.imem_ack    = a;
        fif.imem_rdata  = d;
        fif.instr_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        fif.imem_ack = 1'b0;
        fif.imem_rdata = 32'h0000_0000;
        fif.instr_ready = 1'b0;
        npc_ovr_en = 1'b0;
        npc_ovr = 32'h0000_0000;

        //             rst  ack  rdata          rdy  pc             req  instr          vld  count
        // reset for two cycles, stray ack ignored
        vecs[0]  = mk(1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0000_3000, 1'b0, 32'h0000_0000, 1'b0, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_3000, 1'b0, 32'h0000_0000, 1'b0, 32'd0);
        // released: fetch of 3000 requested
        vecs[2]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_3000, 1'b1, 32'h0000_0000, 1'b0, 32'd0);
        // zero-wait stream
        vecs[3]  = mk(1'b1, 1'b1, 32'hA000_0001, 1'b0, 32'h0000_3000, 1'b0, 32'hA000_0001, 1'b1, 32'd0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3004, 1'b1, 32'hA000_0001, 1'b0, 32'd1);
        vecs[5]  = mk(1'b1, 1'b1, 32'hA000_0002, 1'b1, 32'h0000_3004, 1'b0, 32'hA000_0002, 1'b1, 32'd1);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3008, 1'b1, 32'hA000_0002, 1'b0, 32'd2);
        vecs[7]  = mk(1'b1, 1'b1, 32'hA000_0003, 1'b1, 32'h0000_3008, 1'b0, 32'hA000_0003, 1'b1, 32'd2);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_300C, 1'b1, 32'hA000_0003, 1'b0, 32'd3);
        // memory wait: three cycles without ack, ready in fetch has no effect
        vecs[9]  = mk(1'b1, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_300C, 1'b1, 32'hA000_0003, 1'b0, 32'd3);
        vecs[10] = mk(1'b1, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_300C, 1'b1, 32'hA000_0003, 1'b0, 32'd3);
        vecs[11] = mk(1'b1, 1'b0, 32'h5555_5555, 1'b1, 32'h0000_300C, 1'b1, 32'hA000_0003, 1'b0, 32'd3);
        vecs[12] = mk(1'b1, 1'b1, 32'hA000_0004, 1'b0, 32'h0000_300C, 1'b0, 32'hA000_0004, 1'b1, 32'd3);
        // decode stall for four cycles with stray acks
        vecs[13] = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_300C, 1'b0, 32'hA000_0004, 1'b1, 32'd3);
        vecs[14] = mk(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_300C, 1'b0, 32'hA000_0004, 1'b1, 32'd3);
        vecs[15] = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_300C, 1'b0, 32'hA000_0004, 1'b1, 32'd3);
        vecs[16] = mk(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_300C, 1'b0, 32'hA000_0004, 1'b1, 32'd3);
        vecs[17] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_3010, 1'b1, 32'hA000_0004, 1'b0, 32'd4);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst_n, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
            chk($sformatf("v%0d.pc", i),    pc,                      vecs[i].e_pc);
            chk($sformatf("v%0d.req", i),   {31'd0, fif.imem_req},   {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d.instr", i), fif.instr,               vecs[i].e_instr);
            chk($sformatf("v%0d.valid", i), {31'd0, fif.instr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.count", i), instr_count,             vecs[i].e_count);
            chk($sformatf("v%0d.exc", i),   {31'd0, fetch_exc},      32'd0);
            if (vecs[i].e_req)
                chk($sformatf("v%0d.addr", i), fif.imem_addr, vecs[i].e_pc);
        end

        // Misaligned npc at accept (pc=3010 fetching).
        step(1'b1, 1'b1, 32'hB000_0005, 1'b0);
        chk("mis.hold", {31'd0, fif.instr_valid}, 32'd1);
        npc_ovr_en = 1'b1;
        npc_ovr    = 32'h0000_3006;
        step(1'b1, 1'b0, 32'h0000_0000, 1'b1);
        npc_ovr_en = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis.pc",   pc, 32'h0000_4180);
        chk("mis.exc1", {31'd0, fetch_exc}, 32'd1);
`else
        chk("mis.pc",   pc, 32'h0000_3004);
        chk("mis.exc1", {31'd0, fetch_exc}, 32'd0);
`endif
        chk("mis.count", instr_count, 32'd5);
        chk("mis.req",   {31'd0, fif.imem_req}, 32'd1);
        step(1'b1, 1'b0, 32'h0000_0000, 1'b0);
        chk("mis.exc2", {31'd0, fetch_exc}, 32'd0);

        // Reset while holding a word.
        step(1'b1, 1'b1, 32'hC000_0006, 1'b0);
        chk("rsth.valid", {31'd0, fif.instr_valid}, 32'd1);
        step(1'b0, 1'b0, 32'h0000_0000, 1'b0);
        chk("rsth.valid0", {31'd0, fif.instr_valid}, 32'd0);
        chk("rsth.pc",     pc, 32'h0000_3000);
        chk("rsth.req",    {31'd0, fif.imem_req}, 32'd0);
        chk("rsth.count",  instr_count, 32'd0);
        step(1'b1, 1'b0, 32'h0000_0000, 1'b0);
        chk("rsth.req1",   {31'd0, fif.imem_req}, 32'd1);
        chk("rsth.addr",   fif.imem_addr, 32'h0000_3000);

        // Counter wrap: preload all-ones, then one accept.
        @(negedge clk);
        force dut.count_r = 32'hFFFF_FFFF;
        #1;
        release dut.count_r;
        step(1'b1, 1'b1, 32'hD000_0007, 1'b0);
        chk("wrap.pre", instr_count, 32'hFFFF_FFFF);
        step(1'b1, 1'b0, 32'h0000_0000, 1'b1);
        chk("wrap.count", instr_count, 32'h0000_0000);
        chk("wrap.pc",    pc, 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
